// File: rtl/frontier_scan.sv
// Per-lane BFS frontier manager: ping-pong bitmaps, scan emits one active vertex per cycle, then one end token.
// Latency: vertex at local index k appears k+2 cycles after iteration_start; end token 2^LOCAL_V_WIDTH+2 cycles after.
// Backpressure: none; downstream must accept every strobe. Updates are accepted in every state.
//
// Ports:
//   clk                            single rising-edge clock
//   rst[c]                         async active-high reset of lane c (bitmaps, FSM, outputs)
//   iteration_start / pull_mode    broadcast scan start pulse and its pull-first flag
//   update_v_id / update_v_valid   per-lane vertex to add to that lane's next frontier
//   front_active_v_*               per-lane emitted vertex (id, updated, pull_first_flag, valid)
//   front_iteration_end(_valid)    per-lane end token; end=1 when the lane emitted nothing
//   busy                           lane is scanning or presenting its end token
module frontier_scan #(
    parameter int V_ID_WIDTH    = 32,
    parameter int CORE_NUM      = 16,
    parameter int LOCAL_V_WIDTH = 6
) (
    input  logic                             clk,
    input  logic [CORE_NUM-1:0]              rst,
    input  logic                             iteration_start,
    input  logic                             pull_mode,
    input  logic [CORE_NUM*V_ID_WIDTH-1:0]   update_v_id,
    input  logic [CORE_NUM-1:0]              update_v_valid,
    output logic [CORE_NUM*V_ID_WIDTH-1:0]   front_active_v_id,
    output logic [CORE_NUM-1:0]              front_active_v_updated,
    output logic [CORE_NUM-1:0]              front_active_v_pull_first_flag,
    output logic [CORE_NUM-1:0]              front_active_v_valid,
    output logic [CORE_NUM-1:0]              front_iteration_end,
    output logic [CORE_NUM-1:0]              front_iteration_end_valid,
    output logic [CORE_NUM-1:0]              busy
);
    localparam int CW    = $clog2(CORE_NUM);
    localparam int DEPTH = 1 << LOCAL_V_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_END} state_t;

    for (genvar c = 0; c < CORE_NUM; c++) begin : g_lane
        state_t                   state, state_nxt;
        logic [DEPTH-1:0]         bm0, bm1;
        logic [DEPTH-1:0]         cur;
        logic                     sel;
        logic [LOCAL_V_WIDTH-1:0] idx;
        logic                     emitted;
        logic                     pm_q;
        logic                     accept, hit;

        logic [V_ID_WIDTH-1:0]    uid;
        logic [LOCAL_V_WIDTH-1:0] uloc;
        logic                     uok;
        logic                     wsel;
        logic [V_ID_WIDTH-1:0]    hit_id;

        logic [V_ID_WIDTH-1:0]    id_q;
        logic                     vld_q, pf_q, end_q, endv_q, busy_q;

        assign uid  = update_v_id[c*V_ID_WIDTH +: V_ID_WIDTH];
        assign uloc = uid[CW +: LOCAL_V_WIDTH];
        // Any local-index bit beyond the bitmap depth means the vertex is not ours to hold.
        assign uok  = update_v_valid[c] && ((uid >> (CW + LOCAL_V_WIDTH)) == '0);
        assign cur  = sel ? bm1 : bm0;
        // nxt is B[~sel]; on the flip cycle the post-flip nxt is B[old sel].
        assign wsel = accept ? sel : ~sel;
        assign hit_id = (V_ID_WIDTH'(idx) << CW) | V_ID_WIDTH'(c);

        always_comb begin
            state_nxt = state;
            accept    = 1'b0;
            hit       = 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (iteration_start) begin
                        accept    = 1'b1;
                        state_nxt = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    hit = cur[idx];
                    if (idx == '1) state_nxt = ST_END;
                end
                ST_END:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst[c]) begin
            if (rst[c]) state <= ST_IDLE;
            else        state <= state_nxt;
        end

        always_ff @(posedge clk or posedge rst[c]) begin
            if (rst[c]) begin
                bm0     <= '0;
                bm1     <= '0;
                sel     <= 1'b0;
                idx     <= '0;
                emitted <= 1'b0;
                pm_q    <= 1'b0;
                id_q    <= '0;
                vld_q   <= 1'b0;
                pf_q    <= 1'b0;
                end_q   <= 1'b0;
                endv_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                if (accept) begin
                    sel     <= ~sel;
                    idx     <= '0;
                    emitted <= 1'b0;
                    pm_q    <= pull_mode;
                end
                if (state == ST_SCAN) begin
                    idx <= idx + 1'b1;
                    if (hit) emitted <= 1'b1;
                end
                // Scan clears what it visits so cur is empty when it becomes nxt again.
                if (hit) begin
                    if (sel) bm1[idx] <= 1'b0;
                    else     bm0[idx] <= 1'b0;
                end
                // wsel never equals sel during SCAN, so this cannot collide with the clear.
                if (uok) begin
                    if (wsel) bm1[uloc] <= 1'b1;
                    else      bm0[uloc] <= 1'b1;
                end

                vld_q  <= hit;
                id_q   <= hit ? hit_id : '0;
                pf_q   <= hit & pm_q;
                endv_q <= (state == ST_END);
                end_q  <= (state == ST_END) & ~emitted;

                // Busy covers the scan and the cycle the end token is presented.
                if (accept)      busy_q <= 1'b1;
                else if (endv_q) busy_q <= 1'b0;
            end
        end

        assign front_active_v_id[c*V_ID_WIDTH +: V_ID_WIDTH] = id_q;
        assign front_active_v_updated[c]         = vld_q;
        assign front_active_v_pull_first_flag[c] = pf_q;
        assign front_active_v_valid[c]           = vld_q;
        assign front_iteration_end[c]            = end_q;
        assign front_iteration_end_valid[c]      = endv_q;
        assign busy[c]                           = busy_q;
    end
endmodule

// File: doc/frontier_scan.md
# frontier_scan

Per-core BFS frontier manager feeding `apply_iteration_end`. Each core lane holds ping-pong next/current frontier bitmaps for its locally owned vertices. Lanes collect updated vertices during an iteration, then on `iteration_start` scan the current bitmap and emit one active vertex per cycle on the `front_active_v_*` bus. Each lane then emits a per-lane end token, `front_iteration_end = 1` if its frontier was empty, which `apply_iteration_end` ANDs into the global termination flag.

## Interface
Parameters:
- `V_ID_WIDTH`, 32: vertex id width.
- `CORE_NUM`, 16: lanes; power of 2; lane c owns vertex ids with `id % CORE_NUM == c`.
- `LOCAL_V_WIDTH`, 6: log2 of vertices per lane; bitmap depth is `2^LOCAL_V_WIDTH`.

Ports:
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  CORE_NUM  : asynchronous, active-high; bit c resets lane c only.
- `iteration_start`  in  1  : one-cycle pulse, broadcast to all lanes.
- `pull_mode`  in  1  : pull-first flag for the starting iteration; sampled with `iteration_start`.
- `update_v_id`  in  CORE_NUM*V_ID_WIDTH  : lane c slice is a vertex to add to lane c's next frontier.
- `update_v_valid`  in  CORE_NUM  : qualifies `update_v_id` per lane.
- `front_active_v_id`  out  CORE_NUM*V_ID_WIDTH  : emitted global vertex id.
- `front_active_v_updated`  out  CORE_NUM  : 1 whenever the vertex is valid.
- `front_active_v_pull_first_flag`  out  CORE_NUM  : latched `pull_mode` while the vertex is valid.
- `front_active_v_valid`  out  CORE_NUM  : vertex strobe.
- `front_iteration_end`  out  CORE_NUM  : 1 if the lane emitted zero vertices this iteration; qualified by `front_iteration_end_valid`.
- `front_iteration_end_valid`  out  CORE_NUM  : one-cycle end-token strobe.
- `busy`  out  CORE_NUM  : lane is in SCAN or END.

## Operation
- Local index is `id >> log2(CORE_NUM)`. If any index bit at or above `LOCAL_V_WIDTH` is set, the update is dropped. The low `log2(CORE_NUM)` bits are not checked; they must equal c.
- Per-lane state: bitmaps B0 and B1, a `sel` bit (cur = B[sel], nxt = B[~sel]), a scan counter `idx` of width `LOCAL_V_WIDTH`, an `emitted` flag, and the latched `pull_mode`.
- Updates set nxt[local]. Setting a bit that is already set has no effect. Updates are accepted in every state.
- FSM:
  - IDLE: on `iteration_start`, flip `sel`, set `idx=0`, clear `emitted`, latch `pull_mode`, and go to SCAN.
  - SCAN: each cycle, test cur[idx].
    - If set: emit the vertex with id = `idx*CORE_NUM + c`, clear cur[idx], and set `emitted`.
    - Then increment `idx`. When `idx` is all-ones after testing, go to END.
  - END: assert `front_iteration_end_valid` for one cycle with `front_iteration_end = ~emitted`, then go to IDLE.
- `iteration_start` outside IDLE is ignored.
- An update in the same cycle as the accepted `iteration_start` writes the post-flip nxt, so it belongs to the next iteration.
- Because SCAN clears every bit it visits, cur is all-zero on return to IDLE. The new nxt therefore needs no clear on flip.
- Output validity:
  - `front_active_v_valid` and `front_iteration_end_valid` are never both high in a lane.
  - When a strobe is low, its data outputs are 0.
- Reset, including mid-scan: both bitmaps are cleared, `sel=0`, `idx=0`, FSM goes to IDLE, and all lane outputs go to 0. No end token is produced for the aborted iteration.
- All outputs are registered.

## Timing
- Reset value of every output is 0.
- `iteration_start` is sampled at edge T0.
  - The vertex at local index k appears after edge T0+1+k, for one cycle.
  - The end token appears after edge T0+1+2^LOCAL_V_WIDTH, for one cycle.
  - `busy` rises after T0 and falls after the end-token cycle.
- A scan always takes a fixed 2^LOCAL_V_WIDTH+1 cycles regardless of occupancy. Lanes started together therefore emit end tokens in the same cycle.
- Maximum output rate is one vertex per lane per cycle. There is no backpressure; downstream must always accept.
- `update_v_*` visibility:
  - An update is written at the edge that samples it.
  - It is visible only after the next accepted `iteration_start`, never in the current scan.

## Test plan
Bench parameters: `CORE_NUM=4`, `LOCAL_V_WIDTH=3`, `V_ID_WIDTH=32`.
- Reset with all inputs 0 -> all outputs 0 and `busy=0` one cycle after reset release.
- Updates: lane 1 ids {5, 29}, lane 2 id 2; then start with `pull_mode=1`.
  - Lane 1 emits 5 after T0+2 and 29 after T0+8, each with `updated=1` and `pull_first=1`.
  - Lane 2 emits 2 after T0+1.
  - At T0+9, end tokens: lanes 1 and 2 `end=0`, lanes 0 and 3 `end=1`; all four `end_valid=1`.
- Start with all bitmaps empty -> no `valid` for 8 cycles, then all lanes give `end_valid=1`, `end=1`.
- Lane 0 update id 4 during SCAN -> not emitted this scan; emitted as id 4 after T1+2 of the next start.
- Second `iteration_start` mid-scan -> ignored, end token timing unchanged. Lane 0 update id 40 (local index 10) -> dropped, no emission.
- Assert `rst[1]` mid-scan -> lane 1 outputs 0 and bitmaps cleared, no end token from lane 1. Other lanes complete unaffected.
